pipe_stage_buf: RTL

//   Parametrised pipeline-stage register with valid/ready handshake, replacing fixed per-stage regs (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_buf.sv | 116 +++++++++++
 1 files changed

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready pipeline stage register with flush, bubble masking, optional 2-entry skid and stall counter
module pipe_stage_buf #(
    parameter int DATA_W   = 160,
    parameter int CTRL_W   = 12,
    parameter int SKID     = 1,
    parameter int CLR_DATA = 0,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    state_t             r_state, w_state_nxt;
    logic               r_rdy;
    logic [CTRL_W-1:0]  r_head_ctrl, r_skid_ctrl;
    logic [DATA_W-1:0]  r_head_data, r_skid_data;
    logic [CNT_W-1:0]   r_stall;
    logic               w_in_fire, w_out_fire, w_load_head, w_load_skid, w_skid_to_head;
    assign out_valid  = r_state != EMPTY;
    assign in_ready   = (SKID != 0) ? r_rdy : (!out_valid || out_ready);
    assign out_ctrl   = out_valid ? r_head_ctrl : '0;
    assign out_data   = r_head_data;
    assign occupancy  = r_state;
    assign stall_cnt  = r_stall;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    // Next state and load strobes; FULL is only reachable with the skid enabled, flush overrides everything
    always_comb begin
        w_state_nxt    = r_state;
        w_load_head    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_head = 1'b0;
        unique case (r_state)
            EMPTY: begin
                w_state_nxt = w_in_fire ? ONE : EMPTY;
                w_load_head = w_in_fire;
            end
            ONE: begin
                if (w_in_fire && (w_out_fire || SKID == 0)) begin
                    w_load_head = 1'b1;
                end else if (w_in_fire) begin
                    w_state_nxt = FULL;
                    w_load_skid = 1'b1;
                end else if (w_out_fire) begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL: begin
                w_state_nxt    = w_out_fire ? ONE : FULL;
                w_skid_to_head = w_out_fire;
            end
            default: w_state_nxt = EMPTY;
        endcase
        if (flush) begin
            w_state_nxt    = EMPTY;
            w_load_head    = 1'b0;
            w_load_skid    = 1'b0;
            w_skid_to_head = 1'b0;
        end
    end
    // State register; in_ready for the skid variant is registered from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
            r_rdy   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rdy   <= w_state_nxt != FULL;
        end
    end
    // Head and skid payload; flush clears control, and data only when CLR_DATA is set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head_ctrl <= '0;
            r_head_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else begin
            if (w_load_head) begin
                r_head_ctrl <= in_ctrl;
                r_head_data <= in_data;
            end else if (w_skid_to_head) begin
                r_head_ctrl <= r_skid_ctrl;
                r_head_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_ctrl <= in_ctrl;
                r_skid_data <= in_data;
            end
            if (flush) begin
                r_head_ctrl <= '0;
                r_skid_ctrl <= '0;
                if (CLR_DATA != 0) begin
                    r_head_data <= '0;
                    r_skid_data <= '0;
                end
            end
        end
    end
    // Saturating count of back-pressured cycles, untouched by flush
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_stall <= '0;
        else if (out_valid && !out_ready && !(&r_stall)) r_stall <= r_stall + CNT_W'(1);
    end
endmodule
